top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top_pkg.sv | 32 +++
 rtl/top_if.sv | 26 ++
 rtl/uart_byte_tx.sv | 94 +++++++++
 rtl/top.sv | 121 ++++++++++++
 tb/tb_top.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/top_pkg.sv
//------------------------------------------------------------------------------
// Module  : top_pkg
// Purpose : Shared definitions for the fixed-message UART transmitter:
//           message length, message byte ROM ("Hello A11\n"), index width
//           and the controller state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package top_pkg;

    localparam int MSG_LEN = 10;
    localparam int IDX_W   = $clog2(MSG_LEN);

    // "Hello A11\n"
    localparam logic [7:0] MSG_ROM [MSG_LEN] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F,
        8'h20, 8'h41, 8'h31, 8'h31, 8'h0A
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        NEXT = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/top_if.sv
//------------------------------------------------------------------------------
// Module  : top_if
// Purpose : Byte-stream handshake between the message sequencer (master) and
//           the UART byte serialiser (slave), plus the serial line it drives.
// Signals : start  - master requests a new frame with data
//           data   - byte to transmit
//           busy   - serialiser has a frame in progress
//           done   - one-cycle pulse, one clock before the stop bit ends
//           tx     - registered serial line
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface top_if;
    logic       start;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       tx;

    modport master (output start, output data, input busy, input done, input tx);
    modport slave  (input start, input data, output busy, output done, output tx);
endinterface

`default_nettype wire

// File: rtl/uart_byte_tx.sv
//------------------------------------------------------------------------------
// Module  : uart_byte_tx
// Purpose : 8N1 framing and serialisation of one byte, LSB first. Each bit is
//           held BIT_CYCLES clocks. A start request seen during the last clock
//           of a stop bit launches the next frame with no idle in between.
// Ports   : clk, rst_n (async, active-low), start, data[7:0],
//           busy, done (pulse one clock before frame end), tx (idle high)
// Params  : BIT_CYCLES (>= 2)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_byte_tx #(
    parameter int BIT_CYCLES = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int c_baud_w = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int c_bit_w  = $clog2(10);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(BIT_CYCLES - 1);
    localparam logic [c_baud_w-1:0] c_baud_done = c_baud_w'(BIT_CYCLES - 2);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
    localparam logic [c_bit_w-1:0]  c_last_data = c_bit_w'(8);
    localparam logic [c_bit_w-1:0]  c_stop_bit  = c_bit_w'(9);

    logic                r_busy;
    logic                r_done;
    logic                r_tx;
    logic [c_baud_w-1:0] r_baud_cnt;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic [7:0]          r_shift;

    logic w_baud_last;
    logic w_frame_end;
    logic w_load;

    assign w_baud_last = (r_baud_cnt == c_baud_last);
    assign w_frame_end = r_busy && w_baud_last && (r_bit_cnt == c_stop_bit);
    assign w_load      = start && (!r_busy || w_frame_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (w_load) begin
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_tx       <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= data;
        end else if (r_busy) begin
            if (w_baud_last) begin
                r_baud_cnt <= '0;
                if (r_bit_cnt == c_stop_bit) begin
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_tx      <= 1'b1;
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                    r_tx      <= (r_bit_cnt == c_last_data) ? 1'b1 : r_shift[0];
                    r_shift   <= r_shift >> 1;
                    // With a two-clock bit the pre-end pulse starts on stop-bit entry.
                    r_done    <= (r_bit_cnt == c_last_data) && (c_baud_done == '0);
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + c_baud_one;
                // Pulse lands in the second-to-last stop-bit clock so the
                // sequencer can present the next byte for the final clock.
                r_done     <= (r_bit_cnt == c_stop_bit) && ((r_baud_cnt + c_baud_one) == c_baud_done);
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign tx   = r_tx;

endmodule

`default_nettype wire

// File: rtl/top.sv
//------------------------------------------------------------------------------
// Module  : top
// Purpose : Transmits the fixed 10-byte message "Hello A11\n" as back-to-back
//           UART 8N1 frames starting on the first clock after reset release.
// Ports   : sys_clk (rising edge), rst_n (async, active-low),
//           uart_tx (registered serial out, idle high)
// Params  : CLK_FREQ, BAUD (bit period = CLK_FREQ/BAUD, >= 2),
//           GAP_CYCLES (idle clocks between repetitions, >= 2)
// Config  : TOP_REPEAT_EN defined   -> message repeats after GAP_CYCLES idle
//           TOP_REPEAT_EN undefined -> line stays idle until next reset
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module top
    import top_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int GAP_CYCLES = 50_000
) (
    input  logic sys_clk,
    input  logic rst_n,
    output logic uart_tx
);

    localparam int c_bit_cycles = CLK_FREQ / BAUD;
    localparam int c_gap_w      = $clog2(GAP_CYCLES + 1);
    // Gap state hands over to IDLE one clock early; IDLE spends the final
    // idle clock presenting the start request.
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 2);
    localparam logic [IDX_W-1:0]   c_idx_last = IDX_W'(MSG_LEN - 1);

`ifdef TOP_REPEAT_EN
    localparam logic c_repeat = 1'b1;
`else
    localparam logic c_repeat = 1'b0;
`endif

    top_if bus_if ();

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [c_gap_w-1:0] r_gap_cnt;
    logic               r_start;
    logic [7:0]         r_data;

    assign bus_if.start = r_start;
    assign bus_if.data  = r_data;

    uart_byte_tx #(
        .BIT_CYCLES (c_bit_cycles)
    ) u_byte_tx (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .start (bus_if.start),
        .data  (bus_if.data),
        .busy  (bus_if.busy),
        .done  (bus_if.done),
        .tx    (bus_if.tx)
    );

    assign uart_tx = bus_if.tx;

    // Start request comes out of reset already asserted with byte 0 so the
    // first start bit goes out on the very first edge after release.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_start   <= 1'b1;
            r_data    <= MSG_ROM[0];
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_start && !bus_if.busy) begin
                        r_state <= SEND;
                        r_start <= 1'b0;
                    end
                end
                SEND: begin
                    if (bus_if.done) begin
                        r_state <= NEXT;
                        if (r_idx != c_idx_last) begin
                            r_start <= 1'b1;
                            r_data  <= MSG_ROM[r_idx + IDX_W'(1)];
                        end
                    end
                end
                // Occupies the last stop-bit clock; the serialiser picks up
                // the pending request on the same edge that ends the frame.
                NEXT: begin
                    r_start <= 1'b0;
                    if (r_idx == c_idx_last) begin
                        r_idx     <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= GAP;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= SEND;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_state <= IDLE;
                        r_start <= c_repeat;
                        r_data  <= MSG_ROM[0];
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_top.sv
//------------------------------------------------------------------------------
// Module  : tb_top
// Purpose : Self-checking bench for top. A reference model derives the ideal
//           line level from the message text and 8N1 timing; an independent
//           edge-triggered decoder recovers bytes from the line.
// Config  : TOP_REPEAT_EN selects the repetition scenario (GAP_CYCLES=1000).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_top;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
`ifdef TOP_REPEAT_EN
    localparam int GAP      = 1000;
`else
    localparam int GAP      = 50_000;
`endif
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * BIT;
    localparam int MSG_CYC  = 10 * FRAME;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    string msg_text = "Hello A11\n";
    int    total = 0;
    int    bad   = 0;

    top_if tb_if ();

    top #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .GAP_CYCLES (GAP)
    ) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .uart_tx (tb_if.tx)
    );

    always #10 clk = ~clk;

    // Ideal line level n clocks after the first start edge of a message.
    function automatic logic ref_level(input int n);
        int         byte_i;
        int         bit_i;
        logic [7:0] ch;
        if (n < 0 || n >= MSG_CYC) return 1'b1;
        byte_i = n / FRAME;
        bit_i  = (n % FRAME) / BIT;
        if (bit_i == 0) return 1'b0;
        if (bit_i == 9) return 1'b1;
        ch = msg_text[byte_i];
        return ch[bit_i-1];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (tb_if.tx !== 1'b1) begin
                bad++;
                $display("FAIL reset_idle[%0d]: uart_tx=%b expected 1", i, tb_if.tx);
            end
        end
        while ($time < 201) #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (tb_if.tx !== 1'b0) begin
            bad++;
            $display("FAIL first_start_bit: uart_tx=%b expected 0 at first edge after release", tb_if.tx);
        end
    endtask

    // Runs from n=1 to the end of the message (n=0 already sampled).
    task automatic test_message();
        logic       prev = 1'b0;
        logic       cur;
        logic       in_frame = 1'b1;
        int         n0 = 0;
        int         k = 0;
        logic [7:0] sh = '0;
        logic [7:0] dec_q[$];
        logic [7:0] got;
        logic [7:0] want;
        int         mism = 0, first_bad = -1, edge_bad = 0, frame_err = 0, last_edge = 0;

        for (int n = 1; n < MSG_CYC; n++) begin
            @(posedge clk); #1;
            cur = tb_if.tx;
            if (cur !== ref_level(n)) begin
                mism++;
                if (first_bad < 0) first_bad = n;
            end
            if (cur !== prev) begin
                if ((n % BIT) != 0) edge_bad++;
                last_edge = n;
            end
            if (!in_frame) begin
                if (prev === 1'b1 && cur === 1'b0) begin
                    in_frame = 1'b1;
                    n0 = n;
                    k = 0;
                end
            end else if ((n - n0) == (BIT / 2 + k * BIT)) begin
                if (k == 0) begin
                    if (cur !== 1'b0) frame_err++;
                end else if (k <= 8) begin
                    sh[k-1] = cur;
                end else begin
                    if (cur !== 1'b1) frame_err++;
                    dec_q.push_back(sh);
                    in_frame = 1'b0;
                end
                k++;
            end
            prev = cur;
        end

        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL line_trace: %0d clocks differ from model, first at clock %0d", mism, first_bad);
        end
        total++;
        if (edge_bad != 0) begin
            bad++;
            $display("FAIL edge_alignment: %0d transitions off the %0d-clock grid, expected 0", edge_bad, BIT);
        end
        total++;
        if (frame_err != 0) begin
            bad++;
            $display("FAIL framing: %0d start/stop errors, expected 0", frame_err);
        end
        total++;
        if (dec_q.size() != msg_text.len()) begin
            bad++;
            $display("FAIL byte_count: decoded %0d bytes, expected %0d", dec_q.size(), msg_text.len());
        end
        for (int i = 0; i < msg_text.len(); i++) begin
            got  = (i < dec_q.size()) ? dec_q[i] : 8'hxx;
            want = msg_text[i];
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL byte[%0d]: got %h expected %h", i, got, want);
            end
        end
        total++;
        if (last_edge != MSG_CYC - BIT) begin
            bad++;
            $display("FAIL last_stop_edge: last transition at clock %0d expected %0d", last_edge, MSG_CYC - BIT);
        end
    endtask

`ifdef TOP_REPEAT_EN
    task automatic test_gap();
        int         ones = 0;
        logic       seen_start = 1'b0;
        logic [7:0] sh = '0;
        logic       stop_ok = 1'b0;
        logic [7:0] want;
        for (int i = 0; i < GAP + 2 * BIT && !seen_start; i++) begin
            @(posedge clk); #1;
            if (tb_if.tx === 1'b1) ones++;
            else seen_start = 1'b1;
        end
        total++;
        if (!seen_start || ones != GAP) begin
            bad++;
            $display("FAIL gap_length: idle clocks=%0d restarted=%0b expected %0d then start", ones, seen_start, GAP);
        end
        if (seen_start) begin
            for (int c = 1; c < FRAME; c++) begin
                @(posedge clk); #1;
                if ((c % BIT) == BIT / 2) begin
                    if (c / BIT >= 1 && c / BIT <= 8) sh[c/BIT-1] = tb_if.tx;
                    if (c / BIT == 9) stop_ok = (tb_if.tx === 1'b1);
                end
            end
            want = msg_text[0];
            total++;
            if (sh !== want || !stop_ok) begin
                bad++;
                $display("FAIL repeat_byte0: got %h stop=%0b expected %h stop=1", sh, stop_ok, want);
            end
        end
    endtask
`else
    task automatic test_idle();
        int highs = 0;
        for (int i = 0; i < 10_000; i++) begin
            @(posedge clk); #1;
            if (tb_if.tx === 1'b1) highs++;
        end
        total++;
        if (highs != 10_000) begin
            bad++;
            $display("FAIL idle_after_msg: high for %0d of 10000 clocks, expected 10000", highs);
        end
    endtask
`endif

    task automatic test_reset_midframe();
        int         tgt = 0;
        int         hold;
        int         mism = 0;
        int         low_in_rst = 0;
        logic [7:0] sh = '0;
        logic       stop_ok = 1'b0;
        logic [7:0] want;

        for (int t = 0; t < 1000; t++) begin
            tgt = 3 * FRAME + BIT + $urandom_range(0, FRAME - 2 * BIT - 1);
            if (ref_level(tgt) == 1'b0) break;
        end

        #4 rst_n = 1'b0;
        #1;
        total++;
        if (tb_if.tx !== 1'b1) begin
            bad++;
            $display("FAIL reset_reassert: uart_tx=%b expected 1", tb_if.tx);
        end
        repeat (3) @(posedge clk);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (tb_if.tx !== 1'b0) begin
            bad++;
            $display("FAIL restart_start_bit: uart_tx=%b expected 0", tb_if.tx);
        end
        for (int n = 1; n <= tgt; n++) begin
            @(posedge clk); #1;
            if (tb_if.tx !== ref_level(n)) mism++;
        end
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL pre_abort_trace: %0d clocks differ from model before clock %0d", mism, tgt);
        end

        #4 rst_n = 1'b0;
        #1;
        total++;
        if (tb_if.tx !== 1'b1) begin
            bad++;
            $display("FAIL async_abort: uart_tx=%b expected 1 immediately after rst_n fall at clock %0d", tb_if.tx, tgt);
        end
        hold = $urandom_range(2, 20);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (tb_if.tx !== 1'b1) low_in_rst++;
        end
        total++;
        if (low_in_rst != 0) begin
            bad++;
            $display("FAIL held_in_reset: uart_tx low on %0d of %0d reset clocks", low_in_rst, hold);
        end

        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (tb_if.tx !== 1'b0) begin
            bad++;
            $display("FAIL restart_after_abort: uart_tx=%b expected fresh start bit 0", tb_if.tx);
        end
        for (int c = 1; c < FRAME; c++) begin
            @(posedge clk); #1;
            if ((c % BIT) == BIT / 2) begin
                if (c / BIT >= 1 && c / BIT <= 8) sh[c/BIT-1] = tb_if.tx;
                if (c / BIT == 9) stop_ok = (tb_if.tx === 1'b1);
            end
        end
        want = msg_text[0];
        total++;
        if (sh !== want || !stop_ok) begin
            bad++;
            $display("FAIL first_byte_after_abort: got %h stop=%0b expected %h stop=1", sh, stop_ok, want);
        end
    endtask

    initial begin
        test_reset();
        test_message();
`ifdef TOP_REPEAT_EN
        test_gap();
`else
        test_idle();
`endif
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
